// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and count-width helper for muldiv_ctrl
package muldiv_pkg;
  localparam int W_DEF = 32;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, FIX = 2'b10} state_e;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: one shift-add multiply or restore-subtract divide step on {acc, q}; ports: is_div_i, m_i (multiplicand/divisor), acc_i/q_i in, acc_o/q_o out
module muldiv_iter_core import muldiv_pkg::*; #(
  parameter int WIDTH = W_DEF
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH:0]   sum, sh;
  logic [WIDTH-1:0] diff;
  logic             fits;
  always_comb begin
    sum   = {1'b0, acc_i} + (q_i[0] ? {1'b0, m_i} : '0);
    sh    = {acc_i, q_i[WIDTH-1]};
    fits  = sh >= {1'b0, m_i};
    diff  = sh[WIDTH-1:0] - m_i;
    acc_o = is_div_i ? (fits ? diff : sh[WIDTH-1:0]) : sum[WIDTH:1];
    q_o   = is_div_i ? {q_i[WIDTH-2:0], fits} : {sum[0], q_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative mult/div FSM owning HI/LO; ports: start/op/src_a/src_b issue, hilo_read/hi_we/lo_we/wdata access, busy/stall/done/div_by_zero status, hi/lo
module muldiv_ctrl import muldiv_pkg::*; #(
  parameter int WIDTH = W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_read,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = cnt_w(WIDTH);
  state_e           state_q;
  op_e              op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] m_q, acc_q, q_q, hi_q, lo_q, acc_n, q_n, hi_d, lo_d, abs_a_d, abs_b_d;
  logic [2*WIDTH-1:0] prod_d;
  logic             neg_a_q, neg_b_q, zero_q, busy_q, done_q, dz_q, neg_a_d, neg_b_d;
  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .is_div_i(op_q[1]),
    .m_i     (m_q),
    .acc_i   (acc_q),
    .q_i     (q_q),
    .acc_o   (acc_n),
    .q_o     (q_n)
  );
  // Operands are iterated as magnitudes; signs are reapplied in FIX.
  // A zero divisor holds q_q at |a| so FIX can rebuild src_a for HI.
  always_comb begin
    neg_a_d = ~op[0] & src_a[WIDTH-1];
    neg_b_d = ~op[0] & src_b[WIDTH-1];
    abs_a_d = neg_a_d ? -src_a : src_a;
    abs_b_d = neg_b_d ? -src_b : src_b;
    prod_d  = (neg_a_q ^ neg_b_q) ? -{acc_q, q_q} : {acc_q, q_q};
    hi_d    = ~op_q[1] ? prod_d[2*WIDTH-1:WIDTH] : zero_q ? (neg_a_q ? -q_q : q_q) : (neg_a_q ? -acc_q : acc_q);
    lo_d    = ~op_q[1] ? prod_d[WIDTH-1:0] : zero_q ? '1 : ((neg_a_q ^ neg_b_q) ? -q_q : q_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            op_q    <= op_e'(op);
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            m_q     <= op[1] ? abs_b_d : abs_a_d;
            q_q     <= op[1] ? abs_a_d : abs_b_d;
            acc_q   <= '0;
            cnt_q   <= '0;
            zero_q  <= op[1] & (src_b == '0);
            dz_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (!zero_q) begin
            acc_q <= acc_n;
            q_q   <= q_n;
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          dz_q    <= zero_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy        = busy_q;
  assign stall       = busy_q & (hilo_read | hi_we | lo_we | start);
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: table-driven, hand-sequenced and randomized checks of muldiv_ctrl against an arithmetic model
module tb_muldiv_ctrl;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, hilo_read = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0, src_b = '0, wdata = '0;
  logic        busy, stall, done, div_by_zero;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hilo_read(hilo_read), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic d);
    longint      sp;
    logic [63:0] up;
    int          sq, sr;
    d = 1'b0;
    h = '0;
    l = '0;
    if (o == 2'b00) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      {h, l} = sp;
    end else if (o == 2'b01) begin
      up = 64'(a) * 64'(b);
      {h, l} = up;
    end else if (b == 0) begin
      h = a;
      l = '1;
      d = 1'b1;
    end else if (o == 2'b10) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        l = 32'h8000_0000;
        h = 0;
      end else begin
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        l = sq;
        h = sr;
      end
    end else begin
      l = a / b;
      h = a % b;
    end
  endfunction

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed);
    int n, dn;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    chk({name, ".busy"}, 64'(busy), 64'(1));
    n = 1;
    dn = 0;
    while (busy && n < 100) begin
      if (done) dn++;
      @(negedge clk);
      n++;
    end
    chk({name, ".latency"}, 64'(n), 64'(34));
    chk({name, ".done"}, 64'(done), 64'(1));
    chk({name, ".early_done"}, 64'(dn), 64'(0));
    chk({name, ".hi"}, 64'(hi), 64'(eh));
    chk({name, ".lo"}, 64'(lo), 64'(el));
    chk({name, ".dz"}, 64'(div_by_zero), 64'(ed));
    @(negedge clk);
    chk({name, ".done_once"}, 64'(done), 64'(0));
  endtask

  initial begin
    logic [31:0] eh, el, a, b;
    logic        ed;
    logic [1:0]  o;
    int          n, bad;
    vecs[0] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[4] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6] = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
    vecs[8] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};

    #2;
    chk("reset.busy", 64'(busy), 64'(0));
    chk("reset.stall", 64'(stall), 64'(0));
    chk("reset.done", 64'(done), 64'(0));
    chk("reset.dz", 64'(div_by_zero), 64'(0));
    chk("reset.hilo", {hi, lo}, 64'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);

    // mthi/mtlo while idle, and hilo_read while idle does not stall
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678; hilo_read = 1'b1;
    chk("idle.stall", 64'(stall), 64'(0));
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0; hilo_read = 1'b0;
    chk("mthi_mtlo", {hi, lo}, {32'h1234_5678, 32'h1234_5678});

    // write and start in the same cycle: write lands, op overwrites at FIX
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF; start = 1'b1; op = 2'b01; src_a = 3; src_b = 5;
    @(negedge clk);
    hi_we = 1'b0; start = 1'b0;
    chk("wr_start.hi", 64'(hi), 64'(32'hDEAD_BEEF));
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("wr_start.result", {hi, lo}, {32'h0, 32'd15});

    // stall from hilo_read at busy cycle 5; start and mthi while busy are ignored
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 32'hFFFF_FFF0; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    bad = 0;
    while (busy && n < 100) begin
      if (n == 5) hilo_read = 1'b1;
      if (n == 8) begin start = 1'b1; op = 2'b11; src_a = 99; src_b = 7; end
      if (n == 10) begin hi_we = 1'b1; wdata = 32'hAAAA_5555; end
      if (n == 12) hi_we = 1'b0;
      if (n == 20) start = 1'b0;
      #1;
      if (stall !== (n >= 5)) bad++;
      @(negedge clk);
      n++;
    end
    chk("stall.pattern", 64'(bad), 64'(0));
    chk("stall.latency", 64'(n), 64'(34));
    chk("stall.after_fix", 64'(stall), 64'(0));
    chk("stall.result", {hi, lo}, 64'(-144));
    hilo_read = 1'b0;

    // asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; op = 2'b01; src_a = 32'h0001_0000; src_b = 32'h0001_0000;
    @(negedge clk);
    start = 1'b0;
    hilo_read = 1'b1;
    repeat (11) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.busy", 64'(busy), 64'(0));
    chk("arst.stall", 64'(stall), 64'(0));
    chk("arst.hilo", {hi, lo}, 64'(0));
    @(negedge clk);
    rst = 1'b0;
    hilo_read = 1'b0;
    run_op("post_rst", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 5);
        default: b = $urandom;
      endcase
      model(o, a, b, eh, el, ed);
      run_op($sformatf("rand%0d", i), o, a, b, eh, el, ed);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
